// File: rtl/seq_pkg.sv
// Constants shared by the word serializer and the downstream 1011 detector.
// The detector state encodings live here so benches can reuse them.
package seq_pkg;

  localparam int   DEF_WIDTH    = 8;
  localparam logic DEF_IDLE_BIT = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEQ_1    = 3'd1,
    SEQ_10   = 3'd2,
    SEQ_101  = 3'd3,
    SEQ_1011 = 3'd4
  } det_state_e;

endpackage

// File: rtl/ser_shift_reg.sv
// Output shifter: holds the word being sent, counts remaining bits and
// presents the current bit (or the idle fill) from registers.
module ser_shift_reg #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic [WIDTH-1:0]       load_data_i,
  output logic [$clog2(WIDTH):0] cnt_o,
  output logic                   ser_bit_o,
  output logic                   ser_valid_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_bit_q, ser_bit_d;
  logic             ser_valid_q;

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ser_bit_d = IDLE_BIT;
    if (load_i) begin
      sr_d  = load_data_i;
      cnt_d = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      sr_d  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
      cnt_d = cnt_q - CW'(1);
    end
    // Output bit is chosen from next state so it can be registered.
    if (cnt_d != '0) begin
      ser_bit_d = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
    if (reset) begin
      cnt_q       <= '0;
      ser_bit_q   <= IDLE_BIT;
      ser_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= (cnt_d != '0);
    end
  end

  assign cnt_o       = cnt_q;
  assign ser_bit_o   = ser_bit_q;
  assign ser_valid_o = ser_valid_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer: one-word holding buffer behind a valid/ready
// handshake, feeding a shifter that reloads on its last bit for gap-free output.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = DEF_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             load;

  assign in_ready = !hold_full_q && !reset;
  assign accept   = in_valid && in_ready;
  // Reloading while the last bit is still on the line keeps the stream gap-free.
  assign load     = hold_full_q && ((cnt == CW'(0)) || (cnt == CW'(1)));

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    if (reset) begin
      hold_full_q <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
    end
  end

  ser_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .IDLE_BIT (IDLE_BIT)
  ) u_shift (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load && !reset),
    .load_data_i(hold_q),
    .cnt_o      (cnt),
    .ser_bit_o  (ser_bit),
    .ser_valid_o(ser_valid)
  );

  assign busy = hold_full_q || (cnt != '0);

endmodule
